// File: rtl/conv_3_5_div_div_cud.sv
// Signed restoring divider: 24-bit dividend by 8-bit divisor, saturating 16-bit quotient.
// One magnitude step per enabled cycle; result registered on the last BUSY cycle and held.
module conv_3_5_div_div_cud #(
    parameter int ID         = 32'd1,
    parameter int din0_WIDTH = 32'd24,
    parameter int din1_WIDTH = 32'd8,
    parameter int dout_WIDTH = 32'd16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  done,
    output logic                  idle,
    output logic                  ovf,
    output logic                  div0
);
    localparam int AW = din0_WIDTH;
    localparam int BW = din1_WIDTH;
    localparam int QW = din0_WIDTH + 2;
    localparam int CW = $clog2(din0_WIDTH + 1);

    localparam logic signed [QW-1:0] QMAX = $signed({{(QW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}});
    localparam logic signed [QW-1:0] QMIN = $signed({{(QW-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}});
    localparam logic [dout_WIDTH-1:0] DMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] DMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [AW-1:0] qmag;
    logic [BW-1:0] rmag;
    logic [BW-1:0] bmag;
    logic          sa;
    logic          sb;
    logic [BW:0]   trial;
    logic          fit;
    logic          step_last;

    logic signed [QW-1:0] qsgn;
    logic [dout_WIDTH-1:0] res_q;
    logic [BW-1:0]         res_r;
    logic                  res_ovf;
    logic                  res_dz;

    logic unused_id;
    assign unused_id = ^ID;

    // cnt runs 0..AW-1 for the steps; the cycle with cnt == AW registers the result
    assign step_last = (cnt == CW'(AW));
    assign trial     = {rmag, qmag[AW-1]};
    assign fit       = (trial >= {1'b0, bmag});

    assign done = (state == S_DONE);
    assign idle = (state == S_IDLE);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= S_IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_BUSY;
            S_BUSY:  if (step_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        qsgn    = $signed({2'b00, qmag});
        res_q   = qsgn[dout_WIDTH-1:0];
        res_r   = sa ? (-rmag) : rmag;
        res_ovf = 1'b0;
        res_dz  = 1'b0;
        if (sa ^ sb) begin
            qsgn  = -qsgn;
            res_q = qsgn[dout_WIDTH-1:0];
        end
        if (bmag == '0) begin
            res_q  = sa ? DMIN : DMAX;
            res_r  = '0;
            res_dz = 1'b1;
        end else if (qsgn > QMAX) begin
            res_q   = DMAX;
            res_ovf = 1'b1;
        end else if (qsgn < QMIN) begin
            res_q   = DMIN;
            res_ovf = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt  <= '0;
            qmag <= '0;
            rmag <= '0;
            bmag <= '0;
            sa   <= 1'b0;
            sb   <= 1'b0;
            dout <= '0;
            rem  <= '0;
            ovf  <= 1'b0;
            div0 <= 1'b0;
        end else if (ce) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa   <= din0[AW-1];
                        sb   <= din1[BW-1];
                        qmag <= din0[AW-1] ? (-din0) : din0;
                        bmag <= din1[BW-1] ? (-din1) : din1;
                        rmag <= '0;
                        cnt  <= '0;
                    end
                end
                S_BUSY: begin
                    if (step_last) begin
                        dout <= res_q;
                        rem  <= res_r;
                        ovf  <= res_ovf;
                        div0 <= res_dz;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        qmag <= {qmag[AW-2:0], fit};
                        // partial remainder stays below bmag, so BW bits suffice after subtraction
                        rmag <= fit ? (trial[BW-1:0] - bmag) : trial[BW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_3_5_div_div_cud.sv
// Bench for conv_3_5_div_div_cud: vector table through a scoreboard queue,
// plus sequences for ignored starts, clock-enable stall and mid-operation reset.
module tb_conv_3_5_div_div_cud;
    logic        clk;
    logic        rst;
    logic        ce;
    logic        start;
    logic [23:0] din0;
    logic [7:0]  din1;
    logic [15:0] dout;
    logic [7:0]  rem;
    logic        done;
    logic        idle;
    logic        ovf;
    logic        div0;

    typedef struct {
        logic signed [23:0] a;
        logic signed [7:0]  b;
        logic signed [15:0] q;
        logic signed [7:0]  r;
        logic               ov;
        logic               dz;
    } vec_t;

    vec_t sb_q[$];
    vec_t vt[17];
    vec_t vx;
    int   tests;
    int   fails;

    conv_3_5_div_div_cud dut (
        .ap_clk(clk),
        .ap_rst(rst),
        .ce(ce),
        .start(start),
        .din0(din0),
        .din1(din1),
        .dout(dout),
        .rem(rem),
        .done(done),
        .idle(idle),
        .ovf(ovf),
        .div0(div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Scoreboard: every done pops one expected record pushed at issue time
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                check("dout", $signed(dout), e.q);
                check("rem", $signed(rem), e.r);
                check("ovf", ovf, e.ov);
                check("div0", div0, e.dz);
            end
        end
    end

    // Called at a negedge; returns at a negedge in the IDLE cycle after done
    task automatic run_op(input vec_t v, input int exp_lat, input int ce_at, input bit pulse);
        int lat;
        bit got;
        din0  = v.a;
        din1  = v.b;
        start = 1'b1;
        sb_q.push_back(v);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            #1 start = 1'b0;
            @(negedge clk);
            if (lat == 1) check("idle_busy", idle, 0);
            if (ce_at > 0 && lat == ce_at) ce = 1'b0;
            if (ce_at > 0 && lat == ce_at + 10) ce = 1'b1;
            if (pulse && (lat == 5 || lat == 12 || lat == 20)) begin
                start = 1'b1;
                din0  = 24'd1;
                din1  = 8'd1;
            end
            got = done;
        end
        check("latency", lat, exp_lat);
        if (pulse && got) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_after", idle, 1);
        check("dout_hold", $signed(dout), v.q);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;

        vt[0]  = '{24'sd1000,    8'sd7,    16'sd142,    8'sd6,  1'b0, 1'b0};
        vt[1]  = '{-24'sd1000,   8'sd7,   -16'sd142,   -8'sd6,  1'b0, 1'b0};
        vt[2]  = '{24'sd1000,   -8'sd7,   -16'sd142,    8'sd6,  1'b0, 1'b0};
        vt[3]  = '{-24'sd5,      8'sd0,    16'h8000,    8'sd0,  1'b0, 1'b1};
        vt[4]  = '{24'sd5,       8'sd0,    16'sd32767,  8'sd0,  1'b0, 1'b1};
        vt[5]  = '{24'sd8388607, 8'sd1,    16'sd32767,  8'sd0,  1'b1, 1'b0};
        vt[6]  = '{24'h800000,  -8'sd1,    16'sd32767,  8'sd0,  1'b1, 1'b0};
        vt[7]  = '{24'sd100,    -8'sd3,   -16'sd33,     8'sd1,  1'b0, 1'b0};
        vt[8]  = '{24'sd0,       8'sd5,    16'sd0,      8'sd0,  1'b0, 1'b0};
        vt[9]  = '{24'h800000,   8'sd1,    16'h8000,    8'sd0,  1'b1, 1'b0};
        vt[10] = '{24'sd32767,   8'sd1,    16'sd32767,  8'sd0,  1'b0, 1'b0};
        vt[11] = '{-24'sd32768,  8'sd1,    16'h8000,    8'sd0,  1'b0, 1'b0};
        vt[12] = '{24'sd32768,   8'sd1,    16'sd32767,  8'sd0,  1'b1, 1'b0};
        vt[13] = '{-24'sd7,      8'h80,    16'sd0,     -8'sd7,  1'b0, 1'b0};
        vt[14] = '{24'sd0,       8'sd0,    16'sd32767,  8'sd0,  1'b0, 1'b1};
        vt[15] = '{24'sd4000000, 8'h80,   -16'sd31250,  8'sd0,  1'b0, 1'b0};
        vt[16] = '{-24'sd999,    8'sd10,  -16'sd99,    -8'sd9,  1'b0, 1'b0};

        #1;
        check("rst_dout", dout, 0);
        check("rst_rem", rem, 0);
        check("rst_done", done, 0);
        check("rst_idle", idle, 1);
        check("rst_ovf", ovf, 0);
        check("rst_div0", div0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back issue: each op starts in the IDLE cycle after the previous done
        for (int i = 0; i < 17; i++) run_op(vt[i], 26, 0, 1'b0);

        // start pulses (with changed operands) during BUSY and DONE are ignored
        run_op(vt[0], 26, 0, 1'b1);
        repeat (30) @(negedge clk);
        check("idle_no_requeue", idle, 1);

        // ce low for 10 cycles mid-BUSY stretches latency by exactly 10
        run_op(vt[16], 36, 10, 1'b0);

        // reset in the middle of the step phase abandons the operation
        din0  = 24'sd1000;
        din1  = 8'sd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("idle_before_rst", idle, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_dout", dout, 0);
        check("mid_rst_rem", rem, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_div0", div0, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_after_rst", idle, 1);
        vx = vt[7];
        run_op(vx, 26, 0, 1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
